// File: rtl/prbs_sched.sv
// Strobe scheduler for a pair of I/Q prbs9 generators: it reloads the seeds, then
// issues advance strobes every P cycles, either continuously or for a fixed-length burst.
module prbs_sched #(
    parameter int DIV_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_mode,
    input  logic [DIV_W-1:0] i_os_div,
    input  logic [CNT_W-1:0] i_burst_len,
    output logic             o_prbs_en,
    output logic             o_prbs_reload,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_sym_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] sym_count;
    logic             cfg_mode;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_len;

    logic             strobe;
    logic             last_sym;
    logic             accept_start;
    logic [CNT_W-1:0] sym_count_inc;

    assign sym_count_inc = sym_count + CNT_W'(1);

    // An abort sampled in this cycle suppresses the strobe, so no symbol leaks out.
    assign strobe       = (state == RUN) && (div_q == cfg_div) && !i_stop;
    assign last_sym     = cfg_mode && (sym_count_inc == cfg_len);
    assign accept_start = (state == IDLE) && i_start && !i_stop;

    // NOTE: every variable assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept_start) state_nxt = LOAD;
            LOAD: begin
                if (i_stop)                        state_nxt = IDLE;
                else if (cfg_mode && cfg_len == '0) state_nxt = DONE;
                else                               state_nxt = RUN;
            end
            RUN: begin
                if (i_stop)                 state_nxt = IDLE;
                else if (strobe && last_sym) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_q     <= '0;
            sym_count <= '0;
            cfg_mode  <= 1'b0;
            cfg_div   <= '0;
            cfg_len   <= '0;
        end else begin
            state <= state_nxt;
            if (accept_start) begin
                // Config is frozen here; counters clear so LOAD already reports zero.
                cfg_mode  <= i_mode;
                cfg_div   <= i_os_div;
                cfg_len   <= i_burst_len;
                div_q     <= '0;
                sym_count <= '0;
            end else if (state == RUN) begin
                div_q <= (div_q == cfg_div) ? '0 : div_q + DIV_W'(1);
                if (strobe) sym_count <= sym_count_inc;
            end
        end
    end

    assign o_prbs_en     = strobe;
    assign o_prbs_reload = (state == LOAD);
    assign o_busy        = (state != IDLE);
    assign o_done        = (state == DONE);
    assign o_sym_count   = sym_count;

endmodule

// File: tb/tb_prbs_sched.sv
// Self-checking bench for prbs_sched: directed burst table, corner-case sequences
// and randomized runs compared against a cycle-index arithmetic model.
module tb_prbs_sched;

    localparam int DIV_W = 4;
    localparam int CNT_W = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic             i_stop;
    logic             i_mode;
    logic [DIV_W-1:0] i_os_div;
    logic [CNT_W-1:0] i_burst_len;
    logic             o_prbs_en;
    logic             o_prbs_reload;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_sym_count;

    int n_checks = 0;
    int n_fail   = 0;

    prbs_sched #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_mode       (i_mode),
        .i_os_div     (i_os_div),
        .i_burst_len  (i_burst_len),
        .o_prbs_en    (o_prbs_en),
        .o_prbs_reload(o_prbs_reload),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_sym_count  (o_sym_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit en;
        bit reload;
        bit busy;
        bit done;
        int cnt;
    } exp_t;

    // Cycle k counts from the edge that sampled the start (k=1 is the reload cycle).
    function automatic int cnt_at(int k, bit mode, int p, int l);
        int c;
        if (k < 2) return 0;
        c = (k - 2) / p;
        if (mode && c > l) c = l;
        return c % CNT_MOD;
    endfunction

    function automatic int done_cycle(bit mode, int p, int l);
        return mode ? 2 + p * l : 32'h3fff_ffff;
    endfunction

    function automatic exp_t model(int k, bit mode, int p, int l, int s);
        exp_t e;
        int d = done_cycle(mode, p, l);
        if (s > 0 && s < d && k > s) begin
            e = '{en: 1'b0, reload: 1'b0, busy: 1'b0, done: 1'b0, cnt: cnt_at(s, mode, p, l)};
        end else begin
            e.reload = (k == 1);
            e.done   = (k == d);
            e.busy   = (k >= 1 && k <= d);
            e.en     = (k >= 2 && k < d && ((k - 1) % p == 0) && k != s);
            e.cnt    = cnt_at(k, mode, p, l);
        end
        return e;
    endfunction

    task automatic compare_cycle(input int k, input exp_t e);
        check($sformatf("prbs_en k=%0d", k), 32'(o_prbs_en), 32'(e.en));
        check($sformatf("reload k=%0d", k), 32'(o_prbs_reload), 32'(e.reload));
        check($sformatf("busy k=%0d", k), 32'(o_busy), 32'(e.busy));
        check($sformatf("done k=%0d", k), 32'(o_done), 32'(e.done));
        check($sformatf("sym_count k=%0d", k), 32'(o_sym_count), 32'(e.cnt));
        check($sformatf("exclusive k=%0d", k),
              32'(int'(o_prbs_en) + int'(o_prbs_reload) + int'(o_done) <= 1), 32'd1);
    endtask

    // Called just after a rising edge while idle. s = stop cycle (0 = none);
    // scramble = toggle start/config during the run, which must have no effect.
    task automatic run_one(input bit mode, input int os_div, input int len, input int s,
                           input bit scramble);
        int p    = os_div + 1;
        int d    = done_cycle(mode, p, len);
        int term = (s > 0 && s < d) ? s : d;
        i_mode      = mode;
        i_os_div    = DIV_W'(os_div);
        i_burst_len = CNT_W'(len);
        i_start     = 1'b1;
        i_stop      = 1'b0;
        @(posedge clk); #1;
        for (int k = 1; k <= term + 2; k++) begin
            i_stop  = (k == s);
            i_start = scramble && k <= term ? 1'($urandom) : 1'b0;
            if (scramble) begin
                i_mode      = 1'($urandom);
                i_os_div    = DIV_W'($urandom);
                i_burst_len = CNT_W'($urandom);
            end
            @(negedge clk);
            compare_cycle(k, model(k, mode, p, len, s));
            @(posedge clk); #1;
        end
        i_start = 1'b0;
        i_stop  = 1'b0;
    endtask

    typedef struct {
        bit mode;
        int os_div;
        int len;
        int first_en;
        int done_cyc;
        int cnt;
        int strobes;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int first_en, done_seen, strobes, cnt_done, busy_after;

        vecs[0] = '{1, 3,  5,  5, 22,  5,  5};
        vecs[1] = '{1, 0,  0, -1,  2,  0,  0};
        vecs[2] = '{1, 0,  3,  2,  5,  3,  3};
        vecs[3] = '{1, 1,  2,  3,  6,  2,  2};
        vecs[4] = '{1, 15, 1, 17, 18,  1,  1};
        vecs[5] = '{1, 0, 15,  2, 17, 15, 15};

        rst = 1'b1;
        i_start = 1'b0; i_stop = 1'b0; i_mode = 1'b0;
        i_os_div = '0; i_burst_len = '0;
        repeat (2) @(negedge clk);
        check("reset prbs_en", 32'(o_prbs_en), 0);
        check("reset reload", 32'(o_prbs_reload), 0);
        check("reset busy", 32'(o_busy), 0);
        check("reset done", 32'(o_done), 0);
        check("reset sym_count", 32'(o_sym_count), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed burst table
        foreach (vecs[i]) begin
            i_mode = vecs[i].mode;
            i_os_div = DIV_W'(vecs[i].os_div);
            i_burst_len = CNT_W'(vecs[i].len);
            i_start = 1'b1;
            @(posedge clk); #1;
            i_start = 1'b0;
            first_en = -1; done_seen = -1; strobes = 0; cnt_done = -1; busy_after = -1;
            for (int k = 1; k <= 80; k++) begin
                @(negedge clk);
                if (o_prbs_en) begin
                    strobes++;
                    if (first_en < 0) first_en = k;
                end
                if (o_done && done_seen < 0) begin
                    done_seen = k;
                    cnt_done = int'(o_sym_count);
                end
                if (done_seen > 0 && k == done_seen + 1) begin
                    busy_after = int'(o_busy);
                    @(posedge clk); #1;
                    break;
                end
                @(posedge clk); #1;
            end
            check($sformatf("vec%0d first_en", i), 32'(first_en), 32'(vecs[i].first_en));
            check($sformatf("vec%0d done_cycle", i), 32'(done_seen), 32'(vecs[i].done_cyc));
            check($sformatf("vec%0d strobes", i), 32'(strobes), 32'(vecs[i].strobes));
            check($sformatf("vec%0d sym_count", i), 32'(cnt_done), 32'(vecs[i].cnt));
            check($sformatf("vec%0d busy_after", i), 32'(busy_after), 0);
        end

        // Start and stop together in IDLE: stop wins
        i_mode = 1'b1; i_os_div = '0; i_burst_len = CNT_W'(3);
        i_start = 1'b1; i_stop = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_stop = 1'b0;
        @(negedge clk);
        check("start+stop reload", 32'(o_prbs_reload), 0);
        check("start+stop busy", 32'(o_busy), 0);
        @(posedge clk); #1;

        // Continuous, P=1, count wraps, abort at cycle 30
        run_one(1'b0, 0, 0, 30, 1'b0);

        // Restart and config changes during the run are ignored
        run_one(1'b1, 3, 3, 0, 1'b1);

        // Asynchronous reset mid-burst after three strobes
        run_one(1'b1, 1, 10, 0, 1'b0);
        i_mode = 1'b1; i_os_div = DIV_W'(1); i_burst_len = CNT_W'(10);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            compare_cycle(k, model(k, 1'b1, 2, 10, 0));
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        check("async rst prbs_en", 32'(o_prbs_en), 0);
        check("async rst reload", 32'(o_prbs_reload), 0);
        check("async rst busy", 32'(o_busy), 0);
        check("async rst done", 32'(o_done), 0);
        check("async rst sym_count", 32'(o_sym_count), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post rst idle busy", 32'(o_busy), 0);
            check("post rst no done", 32'(o_done), 0);
        end
        @(posedge clk); #1;
        run_one(1'b1, 1, 10, 0, 1'b0);

        // Randomized runs against the model
        for (int r = 0; r < 16; r++) begin
            bit m  = 1'($urandom);
            int os = int'($urandom % 4);
            int l  = int'($urandom % 16);
            int d  = done_cycle(m, os + 1, l);
            int s;
            if (!m)                   s = int'($urandom_range(40, 1));
            else if ($urandom % 3 == 0) s = int'($urandom_range(d - 1, 1));
            else                      s = 0;
            run_one(m, os, l, s, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
